// File: rtl/sad_accumulator.sv
// sad_accumulator: frame-based |data - reff| reducer (sum or maximum) fed
// by a valid/ready sample stream. One pair per cycle, COUNT pairs per frame,
// single-cycle done pulse with the final result.
module sad_accumulator #(
  parameter int WIDTH = 8,
  parameter int COUNT = 16,
  parameter int ACC_W = WIDTH + $clog2(COUNT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] reff,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] result
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(COUNT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic [WIDTH-1:0] diff;
  logic [ACC_W-1:0] diff_ext;

  // Absolute difference: subtract the smaller operand from the larger so the
  // result always fits in WIDTH bits and is symmetric in its operands.
  assign diff     = (data >= reff) ? (data - reff) : (reff - data);
  assign diff_ext = ACC_W'(diff);
  assign accept   = in_valid && (state_q == ACCUM);

  // Outputs decode straight from the state register, so an asynchronous
  // reset clears them without waiting for a clock edge.
  assign busy     = (state_q == ACCUM);
  assign in_ready = (state_q == ACCUM);
  assign done     = (state_q == DONE);
  assign result   = acc_q;

  // Next-state, accumulator and counter logic.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          mode_d  = mode;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (mode_q) begin
            acc_d = (diff_ext > acc_q) ? diff_ext : acc_q;
          end else begin
            acc_d = acc_q + diff_ext;
          end
          if (cnt_q == LAST_CNT) begin
            // Wrap explicitly: COUNT need not be a power of two.
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

endmodule

// File: tb/tb_sad_accumulator.sv
// tb_sad_accumulator: directed frames with hand-computed results for
// WIDTH = 8, COUNT = 4 (ACC_W = 10).
module tb_sad_accumulator;

  localparam int WIDTH = 8;
  localparam int COUNT = 4;
  localparam int ACC_W = 10;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic             mode;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] reff;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] result;

  int errors = 0;
  int checks = 0;

  sad_accumulator #(
    .WIDTH(WIDTH),
    .COUNT(COUNT),
    .ACC_W(ACC_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .mode    (mode),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data    (data),
    .reff    (reff),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one frame. Pair i is byte i of dv/rv. gap = bubble cycles between
  // pairs; noise pulses start and flips mode during the frame.
  task automatic run_frame(input string tag, input logic m, input logic [31:0] dv,
                           input logic [31:0] rv, input int gap, input bit noise,
                           input int exp_res, input int exp_busy);
    int busy_cycles = 0;
    bit early_done  = 1'b0;
    @(negedge clk);
    start = 1'b1;
    mode  = m;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_ready"}, 32'(in_ready), 1);
    for (int i = 0; i < COUNT; i++) begin
      if (i > 0) begin
        repeat (gap) begin
          if (busy) busy_cycles++;
          if (done) early_done = 1'b1;
          @(negedge clk);
        end
      end
      if (busy) busy_cycles++;
      if (done) early_done = 1'b1;
      in_valid = 1'b1;
      data     = dv[8*i +: 8];
      reff     = rv[8*i +: 8];
      if (noise && i == 2) begin
        start = 1'b1;
        mode  = ~m;
      end
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    check({tag, "_early_done"}, 32'(early_done), 0);
    check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_busy));
    check({tag, "_done"}, 32'(done), 1);
    check({tag, "_result"}, 32'(result), 32'(exp_res));
    mode = 1'b0;
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 0);
    check({tag, "_busy_off"}, 32'(busy), 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    mode     = 1'b0;
    in_valid = 1'b0;
    data     = '0;
    reff     = '0;

    // Reset before any clock edge.
    #3;
    check("rst_ready", 32'(in_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(in_ready), 0);

    // pairs (10,3),(3,10),(255,0),(0,0): SAD 7+7+255+0 = 269, max 255
    run_frame("sad", 1'b0, 32'h00_FF_03_0A, 32'h00_00_0A_03, 0, 1'b0, 269, 4);
    run_frame("max", 1'b1, 32'h00_FF_03_0A, 32'h00_00_0A_03, 0, 1'b0, 255, 4);
    run_frame("max_eq", 1'b1, 32'h05_05_05_05, 32'h05_05_05_05, 0, 1'b0, 0, 4);
    // three 3-cycle bubbles: 4 + 9 busy cycles, done 9 cycles later
    run_frame("bubble", 1'b0, 32'h00_FF_03_0A, 32'h00_00_0A_03, 3, 1'b0, 269, 13);
    run_frame("worst", 1'b0, 32'hFF_FF_FF_FF, 32'h00_00_00_00, 0, 1'b0, 1020, 4);
    run_frame("noise", 1'b0, 32'h00_FF_03_0A, 32'h00_00_0A_03, 0, 1'b1, 269, 4);

    // result holds after done until the next start
    repeat (4) @(negedge clk);
    check("hold_result", 32'(result), 269);
    check("hold_ready", 32'(in_ready), 0);

    // Reset mid-frame after two accepts.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      data     = 8'd200;
      reff     = 8'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid_busy_pre", 32'(busy), 1);
    check("mid_result_pre", 32'(result), 400);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_ready", 32'(in_ready), 0);
    check("mid_rst_result", 32'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit saw_done = 1'b0;
      repeat (4) begin
        @(negedge clk);
        if (done) saw_done = 1'b1;
      end
      check("mid_no_done", 32'(saw_done), 0);
    end
    check("mid_result_post", 32'(result), 0);
    check("mid_idle_ready", 32'(in_ready), 0);

    run_frame("after_rst", 1'b0, 32'h01_01_01_01, 32'h00_00_00_00, 0, 1'b0, 4, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
